// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and single-port memory signals around mem_port_arbiter.
// Pure wiring: no storage, so it adds no latency of its own.
// Backpressure is the arbiter's grant/stall signalling; requesters hold req until gnt.
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  // data port
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  // single-port memory
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  // pipeline hold
  logic        stall;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  // requester/memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, data first by default.
// Grants are combinational; read data returns exactly 1 cycle after grant, fully pipelined.
// Losing requester sees no gnt and stall; ARB_STARVE_GUARD_EN adds a fetch anti-starvation counter.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q;
  state_t      state_d;
  logic        if_gnt;
  logic        d_gnt;
  logic        fetch_first;
  logic        if_rvalid;
  logic        d_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

`ifdef ARB_STARVE_GUARD_EN
  // Consecutive data grants taken while fetch was waiting; saturates at 15.
  logic [3:0] starve_cnt;

  // Track how long fetch has been held off; any fetch grant or fetch withdrawal resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!bus.if_req || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign fetch_first = (starve_cnt == LIMIT);
`else
  // Strict data priority: the limit has no effect without the guard.
  logic unused_limit;
  assign unused_limit = ^LIMIT;
  assign fetch_first  = 1'b0;
`endif

  // Grant selection and memory drive; everything quiet while in reset.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (!rst) begin
      if (bus.d_req && !(fetch_first && bus.if_req)) begin
        d_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
    mem_en = if_gnt | d_gnt;
    mem_we = d_gnt & bus.d_we;
    if (d_gnt) begin
      mem_addr  = bus.d_addr;
      mem_wdata = bus.d_wdata;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
    end
  end

  // Next state: remember which port owns the read data arriving next cycle.
  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (d_gnt && !bus.d_we) begin
      state_d = RESP_D;
    end
  end

  // State register; reset drops any response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response valids, masked during reset so a read granted just before rst never surfaces.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if (!rst) begin
      if_rvalid = (state_q == RESP_IF);
      d_rvalid  = (state_q == RESP_D);
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : 16'h0000;
  assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : 16'h0000;
  assign bus.stall     = (bus.if_req & ~if_gnt) | (bus.d_req & ~d_gnt);

endmodule
